// File: rtl/gol_pkg.sv
// Shared definitions for the 8x8 Game of Life engine: board geometry,
// scheduler phase encoding and built-in pattern identifiers.
package gol_pkg;

    localparam int BOARD_W   = 8;
    localparam int BOARD_H   = 8;
    localparam int CELL_BITS = 6;
    localparam int NUM_CELLS = BOARD_W * BOARD_H;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COPY    = 2'd2,
        ST_COMPUTE = 2'd3
    } state_e;

    localparam logic [1:0] PAT_UW      = 2'd0;
    localparam logic [1:0] PAT_GLIDER  = 2'd1;
    localparam logic [1:0] PAT_BLINKER = 2'd2;
    localparam logic [1:0] PAT_CLEAR   = 2'd3;

endpackage

// File: rtl/gol_frame_divider.sv
// Counts frame ticks (saturating) and flags when enough frames have passed
// for the next generation at the current speed setting.
module gol_frame_divider #(
    parameter int SPEED_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               clear,
    input  logic [SPEED_W-1:0] speed,
    output logic               gen_due
);

    // Wide enough to hold 2^(2^SPEED_W - 1) without overflow.
    localparam int CMP_W = (1 << SPEED_W) + 1;

    logic [SPEED_W-1:0] frame_cnt;
    logic [CMP_W-1:0]   cnt_next;
    logic [CMP_W-1:0]   threshold;

    // speed is used live, so a new value applies from the next tick on.
    always_comb begin
        cnt_next  = CMP_W'(frame_cnt) + CMP_W'(1);
        threshold = CMP_W'(1) << speed;
        gen_due   = (cnt_next >= threshold);
    end

    // NOTE: reset is synchronous here, so rst_n is sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (clear) begin
            frame_cnt <= '0;
        end else if (frame_tick && (frame_cnt != '1)) begin
            frame_cnt <= frame_cnt + SPEED_W'(1);
        end
    end

endmodule

// File: rtl/gol_gen_scheduler.sv
// Phase sequencer for the Game of Life engine: LOAD, COPY (curr->prev) and
// COMPUTE (prev->curr), started on frame boundaries and rate-limited by speed.
module gol_gen_scheduler #(
    parameter int CELL_BITS = 6,
    parameter int GEN_W     = 16,
    parameter int SPEED_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_tick,
    input  logic                 run,
    input  logic                 step_req,
    input  logic                 load_req,
    input  logic [1:0]           pattern_sel,
    input  logic [SPEED_W-1:0]   speed,
    output logic [CELL_BITS-1:0] cell_idx,
    output logic [CELL_BITS-1:0] nbr_idx,
    output logic                 load_en,
    output logic [1:0]           load_pattern,
    output logic                 copy_en,
    output logic                 compute_en,
    output logic                 disp_sel,
    output logic                 gen_done,
    output logic [GEN_W-1:0]     gen_count,
    output logic                 busy
);

    import gol_pkg::*;

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_LOAD    = ST_LOAD;
    localparam logic [1:0] S_COPY    = ST_COPY;
    localparam logic [1:0] S_COMPUTE = ST_COMPUTE;

    localparam int             CELLS     = 1 << CELL_BITS;
    localparam int             PH_W      = CELL_BITS + 1;
    localparam logic [PH_W-1:0] LAST_CELL = PH_W'(CELLS - 1);
    localparam logic [PH_W-1:0] LAST_COMP = PH_W'(CELLS);

    logic [1:0]      state;
    logic [PH_W-1:0] phase_cnt;
    logic            load_pend;
    logic [1:0]      pend_pattern;
    logic            step_pend;
    logic            step_trig;
    logic            gen_due;

    logic load_last;
    logic copy_last;
    logic comp_last;
    logic start_load;
    logic start_copy;
    logic div_clear;

    always_comb begin
        load_last  = (state == S_LOAD)    && (phase_cnt == LAST_CELL);
        copy_last  = (state == S_COPY)    && (phase_cnt == LAST_CELL);
        comp_last  = (state == S_COMPUTE) && (phase_cnt == LAST_COMP);
        start_load = (state == S_IDLE) && frame_tick && load_pend;
        start_copy = (state == S_IDLE) && frame_tick && !load_pend
                     && (step_pend || (run && gen_due));
        div_clear  = start_copy || load_last;
    end

    gol_frame_divider #(
        .SPEED_W (SPEED_W)
    ) u_frame_divider (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .clear      (div_clear),
        .speed      (speed),
        .gen_due    (gen_due)
    );

    // NOTE: every output assigned in this block gets a default first, so no latch is inferred.
    always_comb begin
        load_en    = (state == S_LOAD);
        copy_en    = (state == S_COPY);
        compute_en = (state == S_COMPUTE) && (phase_cnt != '0);
        disp_sel   = (state == S_COMPUTE);
        busy       = (state != S_IDLE);
        cell_idx   = '0;
        nbr_idx    = '0;
        case (state)
            S_LOAD, S_COPY: cell_idx = phase_cnt[CELL_BITS-1:0];
            S_COMPUTE: begin
                // The neighbour fetch runs one cell ahead of the write address.
                nbr_idx = phase_cnt[CELL_BITS-1:0];
                if (phase_cnt != '0) begin
                    cell_idx = CELL_BITS'(phase_cnt - PH_W'(1));
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase_cnt    <= '0;
            load_pattern <= PAT_UW;
            step_trig    <= 1'b0;
            gen_done     <= 1'b0;
        end else begin
            gen_done <= comp_last;
            case (state)
                S_IDLE: begin
                    phase_cnt <= '0;
                    if (start_load) begin
                        state        <= S_LOAD;
                        load_pattern <= pend_pattern;
                    end else if (start_copy) begin
                        state     <= S_COPY;
                        step_trig <= step_pend;
                    end
                end
                S_LOAD: begin
                    phase_cnt <= load_last ? '0 : phase_cnt + PH_W'(1);
                    if (load_last) state <= S_IDLE;
                end
                S_COPY: begin
                    phase_cnt <= copy_last ? '0 : phase_cnt + PH_W'(1);
                    if (copy_last) state <= S_COMPUTE;
                end
                default: begin
                    phase_cnt <= comp_last ? '0 : phase_cnt + PH_W'(1);
                    if (comp_last) state <= S_IDLE;
                end
            endcase
        end
    end

    // A fresh load request outranks the end-of-load clear; the reverse holds
    // for steps, so step pulses arriving during a stepped generation collapse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_pend    <= 1'b1;
            pend_pattern <= PAT_UW;
            step_pend    <= 1'b0;
            gen_count    <= '0;
        end else begin
            if (load_req) begin
                load_pend    <= 1'b1;
                pend_pattern <= pattern_sel;
            end else if (load_last) begin
                load_pend <= 1'b0;
            end

            if (load_last || (comp_last && step_trig)) begin
                step_pend <= 1'b0;
            end else if (step_req && !run) begin
                step_pend <= 1'b1;
            end

            if (load_last) begin
                gen_count <= '0;
            end else if (comp_last) begin
                gen_count <= gen_count + GEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Self-checking bench for gol_gen_scheduler: directed scenarios plus randomized
// frames, each compared against a request/frame-level reference model.
module tb_gol_gen_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       run = 1'b0;
    logic       step_req = 1'b0;
    logic       load_req = 1'b0;
    logic [1:0] pattern_sel = 2'd0;
    logic [2:0] speed = 3'd0;

    logic [5:0]  cell_idx;
    logic [5:0]  nbr_idx;
    logic        load_en;
    logic [1:0]  load_pattern;
    logic        copy_en;
    logic        compute_en;
    logic        disp_sel;
    logic        gen_done;
    logic [15:0] gen_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests, frame counter, generation count.
    bit          m_load_pend;
    logic [1:0]  m_pat;
    bit          m_step_pend;
    int          m_frame_cnt;
    logic [15:0] m_gen_count;

    gol_gen_scheduler dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .run          (run),
        .step_req     (step_req),
        .load_req     (load_req),
        .pattern_sel  (pattern_sel),
        .speed        (speed),
        .cell_idx     (cell_idx),
        .nbr_idx      (nbr_idx),
        .load_en      (load_en),
        .load_pattern (load_pattern),
        .copy_en      (copy_en),
        .compute_en   (compute_en),
        .disp_sel     (disp_sel),
        .gen_done     (gen_done),
        .gen_count    (gen_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_load_pend = 1'b1;
        m_pat       = 2'd0;
        m_step_pend = 1'b0;
        m_frame_cnt = 0;
        m_gen_count = '0;
    endtask

    task automatic pulse_step();
        step_req = 1'b1;
        if (!run) m_step_pend = 1'b1;
        cyc();
        step_req = 1'b0;
    endtask

    task automatic pulse_load(input logic [1:0] sel);
        load_req    = 1'b1;
        pattern_sel = sel;
        m_load_pend = 1'b1;
        m_pat       = sel;
        cyc();
        load_req = 1'b0;
    endtask

    // Issues one frame_tick from IDLE and checks the whole resulting phase.
    // action: 0 = stays idle, 1 = LOAD, 2 = generation.
    task automatic do_frame(input string name, input int inj_at,
                            input bit inj_load, input logic [1:0] inj_sel,
                            input bit inj_step, input bit inj_tick,
                            input bit inj_run_set, input bit inj_run_val,
                            output int action);
        int         total;
        int         k;
        bit         trig;
        bit         chk_cell;
        bit         chk_nbr;
        logic [1:0] lpat;
        logic [5:0] exp_flags;
        logic [5:0] obs_flags;
        logic [5:0] exp_cell;
        logic [5:0] exp_nbr;

        trig = 1'b0;
        if (m_load_pend) begin
            action = 1;
        end else if (m_step_pend || (run && (m_frame_cnt + 1 >= (1 << speed)))) begin
            action = 2;
            trig   = m_step_pend;
        end else begin
            action = 0;
        end
        if (action == 2) m_frame_cnt = 0;
        else if (m_frame_cnt < 7) m_frame_cnt++;
        lpat = m_pat;

        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;

        total = (action == 1) ? 64 : (action == 2) ? 129 : 4;
        for (int i = 0; i < total; i++) begin
            exp_flags = '0;
            exp_cell  = '0;
            exp_nbr   = '0;
            chk_cell  = 1'b1;
            chk_nbr   = 1'b1;
            // flag order: load_en copy_en compute_en disp_sel busy gen_done
            if (action == 1) begin
                exp_flags = 6'b100010;
                exp_cell  = 6'(i);
                chk_nbr   = 1'b0;
            end else if (action == 2 && i < 64) begin
                exp_flags = 6'b010010;
                exp_cell  = 6'(i);
                chk_nbr   = 1'b0;
            end else if (action == 2) begin
                k = i - 64;
                exp_nbr = 6'(k % 64);
                chk_nbr = (k < 64);
                if (k == 0) begin
                    exp_flags = 6'b000110;
                    chk_cell  = 1'b0;
                end else begin
                    exp_flags = 6'b001110;
                    exp_cell  = 6'(k - 1);
                end
            end else begin
                chk_cell = 1'b0;
                chk_nbr  = 1'b0;
            end

            obs_flags = {load_en, copy_en, compute_en, disp_sel, busy, gen_done};
            checks++;
            if (obs_flags !== exp_flags) begin
                errors++;
                $display("FAIL %s flags cycle %0d: got %b expected %b", name, i, obs_flags, exp_flags);
            end
            if (chk_cell) begin
                checks++;
                if (cell_idx !== exp_cell) begin
                    errors++;
                    $display("FAIL %s cell_idx cycle %0d: got %0d expected %0d", name, i, cell_idx, exp_cell);
                end
            end
            if (chk_nbr) begin
                checks++;
                if (nbr_idx !== exp_nbr) begin
                    errors++;
                    $display("FAIL %s nbr_idx cycle %0d: got %0d expected %0d", name, i, nbr_idx, exp_nbr);
                end
            end
            if (action == 1) begin
                checks++;
                if (load_pattern !== lpat) begin
                    errors++;
                    $display("FAIL %s load_pattern cycle %0d: got %0d expected %0d", name, i, load_pattern, lpat);
                end
            end

            if (i == inj_at) begin
                if (inj_run_set) run = inj_run_val;
                if (inj_load) begin
                    load_req    = 1'b1;
                    pattern_sel = inj_sel;
                    m_load_pend = 1'b1;
                    m_pat       = inj_sel;
                end
                if (inj_step) begin
                    step_req = 1'b1;
                    if (!run) m_step_pend = 1'b1;
                end
                if (inj_tick) begin
                    frame_tick = 1'b1;
                    if (m_frame_cnt < 7) m_frame_cnt++;
                end
            end
            cyc();
            load_req   = 1'b0;
            step_req   = 1'b0;
            frame_tick = 1'b0;
        end

        if (action == 1) begin
            m_load_pend = 1'b0;
            m_step_pend = 1'b0;
            m_frame_cnt = 0;
            m_gen_count = '0;
        end else if (action == 2) begin
            m_gen_count = m_gen_count + 16'd1;
            if (trig) m_step_pend = 1'b0;
            checks++;
            if ({gen_done, busy, disp_sel} !== 3'b100) begin
                errors++;
                $display("FAIL %s gen_done/busy/disp_sel at end: got %b expected 100", name, {gen_done, busy, disp_sel});
            end
        end
        checks++;
        if (gen_count !== m_gen_count) begin
            errors++;
            $display("FAIL %s gen_count: got %0d expected %0d", name, gen_count, m_gen_count);
        end
        if (action == 2) begin
            cyc();
            checks++;
            if (gen_done !== 1'b0) begin
                errors++;
                $display("FAIL %s gen_done not a single pulse: got %b expected 0", name, gen_done);
            end
        end
    endtask

    task automatic test_reset();
        int act;
        rst_n = 1'b0;
        cyc();
        cyc();
        model_reset();
        checks++;
        if ({load_en, copy_en, compute_en, disp_sel, busy, gen_done, gen_count, load_pattern} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got %b/%0d/%0d expected all zero",
                     {load_en, copy_en, compute_en, disp_sel, busy, gen_done}, gen_count, load_pattern);
        end
        rst_n = 1'b1;
        cyc();
        do_frame("reset_load", -1, 0, 2'd0, 0, 0, 0, 0, act);
        checks++;
        if (act != 1) begin
            errors++;
            $display("FAIL reset first tick action: got %0d expected 1", act);
        end
    endtask

    task automatic test_run_speed0();
        int act;
        run   = 1'b1;
        speed = 3'd0;
        for (int f = 0; f < 3; f++) begin
            do_frame("speed0", -1, 0, 2'd0, 0, 0, 0, 0, act);
            checks++;
            if (act != 2) begin
                errors++;
                $display("FAIL speed0 frame %0d action: got %0d expected 2", f, act);
            end
        end
    endtask

    task automatic test_speed2();
        int         act;
        logic [7:0] gens;
        logic [15:0] base;
        run   = 1'b1;
        speed = 3'd2;
        gens  = '0;
        base  = gen_count;
        for (int f = 0; f < 8; f++) begin
            do_frame("speed2", -1, 0, 2'd0, 0, 0, 0, 0, act);
            gens[f] = (act == 2);
        end
        checks++;
        if (gens !== 8'b1000_1000 || gen_count !== base + 16'd2) begin
            errors++;
            $display("FAIL speed2 gens: got mask %b count +%0d expected mask 10001000 count +2", gens, gen_count - base);
        end
    endtask

    task automatic test_step();
        int act;
        run = 1'b0;
        repeat (3) pulse_step();
        do_frame("step", -1, 0, 2'd0, 0, 0, 0, 0, act);
        checks++;
        if (act != 2) begin
            errors++;
            $display("FAIL step generation action: got %0d expected 2", act);
        end
        for (int f = 0; f < 2; f++) begin
            do_frame("step_idle", -1, 0, 2'd0, 0, 0, 0, 0, act);
            checks++;
            if (act != 0) begin
                errors++;
                $display("FAIL step idle frame %0d action: got %0d expected 0", f, act);
            end
        end
        run   = 1'b1;
        speed = 3'd3;
        pulse_step();
        do_frame("step_run", -1, 0, 2'd0, 0, 0, 0, 0, act);
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL step with run action: got %0d expected 0", act);
        end
    endtask

    task automatic test_load_during_compute();
        int act;
        run   = 1'b1;
        speed = 3'd0;
        do_frame("load_mid", 80, 1, 2'd1, 1, 0, 1, 0, act);
        checks++;
        if (act != 2) begin
            errors++;
            $display("FAIL load_mid generation action: got %0d expected 2", act);
        end
        do_frame("load_pat1", -1, 0, 2'd0, 0, 0, 0, 0, act);
        checks++;
        if (act != 1 || load_pattern !== 2'd1) begin
            errors++;
            $display("FAIL load after compute: got action %0d pattern %0d expected 1 pattern 1", act, load_pattern);
        end
        do_frame("load_step_cleared", -1, 0, 2'd0, 0, 0, 0, 0, act);
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL step after load action: got %0d expected 0", act);
        end
    endtask

    task automatic test_reset_mid_copy();
        int act;
        run   = 1'b1;
        speed = 3'd0;
        if (m_load_pend) do_frame("pre_reset_load", -1, 0, 2'd0, 0, 0, 0, 0, act);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (copy_en !== 1'b1 || cell_idx !== 6'(i)) begin
                errors++;
                $display("FAIL pre-reset copy cycle %0d: got copy_en %b cell %0d expected 1 %0d", i, copy_en, cell_idx, i);
            end
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        model_reset();
        checks++;
        if ({load_en, copy_en, compute_en, disp_sel, busy, gen_done} !== 6'b0 || gen_count !== 16'd0) begin
            errors++;
            $display("FAIL mid-copy reset: got flags %b gen_count %0d expected 0 0",
                     {load_en, copy_en, compute_en, disp_sel, busy, gen_done}, gen_count);
        end
        cyc();
        do_frame("post_reset_load", -1, 0, 2'd0, 0, 0, 0, 0, act);
        checks++;
        if (act != 1) begin
            errors++;
            $display("FAIL post-reset tick action: got %0d expected 1", act);
        end
    endtask

    task automatic test_random();
        int act;
        for (int f = 0; f < 30; f++) begin
            run   = 1'($urandom % 2);
            speed = 3'($urandom % 3);
            if ($urandom % 3 == 0) repeat (1 + $urandom % 3) pulse_step();
            if ($urandom % 6 == 0) pulse_load(2'($urandom % 4));
            do_frame("random", ($urandom % 2) ? 10 : 80,
                     ($urandom % 5 == 0), 2'($urandom % 4),
                     1'($urandom % 2), 1'($urandom % 2),
                     1'($urandom % 2), 1'($urandom % 2), act);
        end
    endtask

    initial begin
        test_reset();
        test_run_speed0();
        test_speed2();
        test_step();
        test_load_during_compute();
        test_reset_mid_copy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gol_gen_scheduler.md
Name: gol_gen_scheduler

Overview:
- Clock-domain controller that sequences the 8x8 Game of Life update engine: pattern load, copy (curr->prev), and compute (prev->curr).
- Starts phases on frame boundaries and throttles generation rate.
- Arbitrates the board write port between the pattern loader and the update engine.
- Drives the VGA source select, so the display always shows a stable board.

Parameters:
- CELL_BITS, 6, log2 of cell count (64 cells, row-major, 8 wide)
- GEN_W, 16, generation counter width
- SPEED_W, 3, width of speed exponent

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- run  in  1  level; 1 = free-running generations
- step_req  in  1  one-cycle pulse; request a single generation while paused
- load_req  in  1  one-cycle pulse; request pattern reload
- pattern_sel  in  2  pattern id, sampled with load_req
- speed  in  SPEED_W  one generation every 2^speed frames
- cell_idx  out  CELL_BITS  cell address for copy/load/compute write
- nbr_idx  out  CELL_BITS  neighbour-fetch address, one cell ahead during compute
- load_en  out  1  write pattern bit for cell_idx into curr board
- load_pattern  out  2  latched pattern id, stable for the whole LOAD phase
- copy_en  out  1  copy curr[cell_idx] -> prev[cell_idx]
- compute_en  out  1  write next state of cell_idx into curr
- disp_sel  out  1  0 = display curr, 1 = display prev
- gen_done  out  1  one-cycle pulse when a generation finishes
- gen_count  out  GEN_W  generations since last load
- busy  out  1  state != IDLE

Behaviour:
- Reset:
  - state IDLE; all outputs 0; frame_cnt 0.
  - load_pend is set to 1 with pattern 0, so the first frame_tick after reset loads pattern 0.
  - step_pend is 0.
  - Reset asserted mid-phase aborts the phase at the next clock edge.
- Request latching (any state):
  - load_req sets load_pend and captures pattern_sel. A later load_req before service overwrites the captured pattern.
  - step_req sets step_pend only when run=0; it is dropped when run=1. Repeated step_req while pending collapses into one.
- IDLE:
  - On frame_tick, frame_cnt increments, saturating at 2^SPEED_W-1.
  - Same-cycle priority:
    1. load_pend -> LOAD.
    2. step_pend, or (run && frame_cnt+1 >= 2^speed) -> COPY; frame_cnt cleared.
    3. Otherwise stay in IDLE.
  - speed is compared live, so a change takes effect at the next frame_tick.
- LOAD:
  - 64 cycles; load_en=1; cell_idx counts 0..63.
  - On the last cycle: load_pend cleared, gen_count cleared, step_pend cleared, frame_cnt cleared.
  - Next state IDLE.
- COPY:
  - 64 cycles; copy_en=1; cell_idx 0..63; disp_sel=0.
  - Then COMPUTE.
- COMPUTE:
  - disp_sel=1 throughout.
  - Cycle 0 is prime: compute_en=0, nbr_idx=0.
  - Cycles k=1..64: compute_en=1, cell_idx=k-1, nbr_idx=k mod 64. The value is don't-care at k=64.
  - After cycle 64:
    - gen_done pulses for one cycle.
    - gen_count increments, wrapping at 2^GEN_W.
    - step_pend is cleared, but only if this generation was step-triggered.
    - disp_sel returns to 0; next state IDLE.
- Mutual exclusion: at most one of load_en, copy_en, compute_en is high in any cycle.
- frame_tick outside IDLE:
  - Ignored for phase start.
  - Still increments frame_cnt (saturating).
- Phase lengths: a generation is 129 cycles and a load is 64 cycles. Both must complete within vertical blanking (>=1400 clocks), so a phase never spans frames.
- Run toggled mid-generation: the generation completes, and no further automatic starts occur.

Decomposition:
- Shared package gol_pkg:
  - BOARD_W=8, BOARD_H=8, CELL_BITS=6, NUM_CELLS=64
  - state enum {IDLE, LOAD, COPY, COMPUTE}
  - pattern ids: PAT_UW=0, PAT_GLIDER=1, PAT_BLINKER=2, PAT_CLEAR=3
- Sub-module gol_frame_divider: frame_tick counter with saturation, plus the speed compare producing gen_due.
- FSM and phase counter stay in the top module.

Test Plan:
- Reset then one frame_tick:
  - Expect LOAD with load_en high 64 cycles, cell_idx 0..63, load_pattern=0.
  - Expect gen_count=0, busy low afterwards.
- run=1, speed=0:
  - Each frame_tick gives 64 copy_en cycles, then 1 prime cycle, then 64 compute_en cycles.
  - disp_sel=1 exactly during COMPUTE; gen_done 129 cycles after the phase start.
  - gen_count increments by 1 per frame.
- run=1, speed=2 for 8 frame_ticks:
  - Exactly 2 generations (on the 4th and 8th tick); gen_count=2.
- run=0, step_req pulsed 3 times before a frame_tick:
  - Exactly one generation; gen_count+1; further ticks are idle.
  - step_req with run=1 has no extra effect.
- load_req (pattern_sel=1) during COMPUTE, together with a pending step:
  - The current generation finishes.
  - Next frame_tick performs LOAD with load_pattern=1; gen_count=0; step_pend cleared.
- rst_n low at COPY cycle 20:
  - Next cycle: all enables 0, disp_sel=0, state IDLE, load_pend=1.
